// File: rtl/fir_dac_serializer_if.sv
// Sample/DAC bundle between the FIR output stage and its driver: sample strobe,
// FIR data, enable, and the SPI-mode-0 DAC pins plus status flags.
interface fir_dac_serializer_if #(
  parameter int N = 32
);
  logic         ena;
  logic         clk_d;
  logic [N-1:0] y_in;
  logic         dac_sclk;
  logic         dac_mosi;
  logic         dac_cs_n;
  logic         busy;
  logic         sat;
  logic         overrun;

  modport master (
    output ena, clk_d, y_in,
    input  dac_sclk, dac_mosi, dac_cs_n, busy, sat, overrun
  );

  modport slave (
    input  ena, clk_d, y_in,
    output dac_sclk, dac_mosi, dac_cs_n, busy, sat, overrun
  );
endinterface

// File: rtl/fir_dac_serializer.sv
// FIR output stage: scales and saturates each strobed sample to an OUT_W-bit
// signed word and ships it MSB-first to an SPI-mode-0 DAC.
module fir_dac_serializer #(
  parameter int N        = 32,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 8,
  parameter int SCLK_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  fir_dac_serializer_if.slave     bus
);

  localparam int CNT_W = $clog2(OUT_W);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_TOP_C  = CNT_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0] BIT_ZERO_C = {CNT_W{1'b0}};

  localparam logic signed [N-1:0] POS_LIM_C = {{(N-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [N-1:0] NEG_LIM_C = {{(N-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]    WORD_MAX_C = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]    WORD_MIN_C = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Returns {clipped, word}: arithmetic scale then clamp to the signed DAC range.
  function automatic logic [OUT_W:0] conv_word(input logic signed [N-1:0] y);
    logic signed [N-1:0] v;
    logic [OUT_W:0]      r;
    v = y >>> SHIFT;
    if (v > POS_LIM_C) begin
      r = {1'b1, WORD_MAX_C};
    end else if (v < NEG_LIM_C) begin
      r = {1'b1, WORD_MIN_C};
    end else begin
      r = {1'b0, v[OUT_W-1:0]};
    end
    return r;
  endfunction

  state_t             state_r, state_nxt_s;
  logic               clk_d_q_r;
  logic               stb_s;
  logic signed [N-1:0] y_s;
  logic [OUT_W:0]     conv_s;
  logic [OUT_W-1:0]   shreg_r, shreg_nxt_s;
  logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_nxt_s;
  logic [DIV_W-1:0]   div_cnt_r, div_cnt_nxt_s;
  logic               sclk_r, sclk_nxt_s;
  logic               mosi_r, mosi_nxt_s;
  logic               cs_n_r, cs_n_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               sat_r, sat_nxt_s;
  logic               overrun_r, overrun_nxt_s;
  logic               div_hit_s;
  logic               last_fall_s;

  // clk_d is a level from the divider; only its rising edge counts as a sample.
  assign stb_s       = bus.clk_d & ~clk_d_q_r;
  assign y_s         = $signed(bus.y_in);
  assign conv_s      = conv_word(y_s);
  assign div_hit_s   = (div_cnt_r == DIV_LAST_C);
  assign last_fall_s = div_hit_s & sclk_r & (bit_cnt_r == BIT_ZERO_C);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: IDLE -> SHIFT -> GAP -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (stb_s && bus.ena) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_fall_s) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (div_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values; every output leaves through a register.
  always_comb begin
    shreg_nxt_s   = shreg_r;
    bit_cnt_nxt_s = bit_cnt_r;
    div_cnt_nxt_s = div_cnt_r;
    sclk_nxt_s    = sclk_r;
    mosi_nxt_s    = mosi_r;
    cs_n_nxt_s    = cs_n_r;
    busy_nxt_s    = busy_r;
    sat_nxt_s     = sat_r;
    // Any strobe outside IDLE (including the GAP->IDLE edge) drops its sample.
    overrun_nxt_s = overrun_r | (stb_s & (state_r != ST_IDLE));
    case (state_r)
      ST_IDLE: begin
        if (stb_s && bus.ena) begin
          shreg_nxt_s   = conv_s[OUT_W-1:0];
          sat_nxt_s     = conv_s[OUT_W];
          mosi_nxt_s    = conv_s[OUT_W-1];
          bit_cnt_nxt_s = BIT_TOP_C;
          div_cnt_nxt_s = {DIV_W{1'b0}};
          sclk_nxt_s    = 1'b0;
          cs_n_nxt_s    = 1'b0;
          busy_nxt_s    = 1'b1;
        end else begin
          div_cnt_nxt_s = {DIV_W{1'b0}};
          sclk_nxt_s    = 1'b0;
          mosi_nxt_s    = 1'b0;
          cs_n_nxt_s    = 1'b1;
          busy_nxt_s    = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (div_hit_s) begin
          div_cnt_nxt_s = {DIV_W{1'b0}};
          sclk_nxt_s    = ~sclk_r;
          if (sclk_r && (bit_cnt_r == BIT_ZERO_C)) begin
            sclk_nxt_s = 1'b0;
            mosi_nxt_s = 1'b0;
            cs_n_nxt_s = 1'b1;
          end else if (sclk_r) begin
            shreg_nxt_s   = {shreg_r[OUT_W-2:0], 1'b0};
            mosi_nxt_s    = shreg_r[OUT_W-2];
            bit_cnt_nxt_s = bit_cnt_r - CNT_W'(1);
          end else begin
            mosi_nxt_s = mosi_r;
          end
        end else begin
          div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (div_hit_s) begin
          div_cnt_nxt_s = {DIV_W{1'b0}};
          busy_nxt_s    = 1'b0;
        end else begin
          div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        div_cnt_nxt_s = {DIV_W{1'b0}};
        sclk_nxt_s    = 1'b0;
        mosi_nxt_s    = 1'b0;
        cs_n_nxt_s    = 1'b1;
        busy_nxt_s    = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_d_q_r <= 1'b0;
      shreg_r   <= {OUT_W{1'b0}};
      bit_cnt_r <= BIT_ZERO_C;
      div_cnt_r <= {DIV_W{1'b0}};
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      busy_r    <= 1'b0;
      sat_r     <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      clk_d_q_r <= bus.clk_d;
      shreg_r   <= shreg_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      div_cnt_r <= div_cnt_nxt_s;
      sclk_r    <= sclk_nxt_s;
      mosi_r    <= mosi_nxt_s;
      cs_n_r    <= cs_n_nxt_s;
      busy_r    <= busy_nxt_s;
      sat_r     <= sat_nxt_s;
      overrun_r <= overrun_nxt_s;
    end
  end

  assign bus.dac_sclk = sclk_r;
  assign bus.dac_mosi = mosi_r;
  assign bus.dac_cs_n = cs_n_r;
  assign bus.busy     = busy_r;
  assign bus.sat      = sat_r;
  assign bus.overrun  = overrun_r;

endmodule
